// File: rtl/comparator_emulator_if.sv
// Test pulse link between a comparator injector (master) and a comparator
// emulator (slave): pulse gate and inject flag out, halfstrip hits and comparator output back.
interface comparator_emulator_if #(
  parameter int NHS = 32
);
  // pulse_en is a level gate and its rising edge starts a transaction. compin is
  // meaningful only while pulse_en=1. There is no ready: the slave counts an edge
  // that arrives while busy as dropped. halfstrips and compout are registered.
  logic           pulse_en;
  logic           compin;
  logic [NHS-1:0] halfstrips;
  logic           compout;

  modport master (output pulse_en, compin, input halfstrips, compout);
  modport slave  (input pulse_en, compin, output halfstrips, compout);
endinterface

// File: rtl/comparator_emulator.sv
// Comparator ASIC stand-in for loopback self-test: answers each accepted test pulse
// with a delayed, held halfstrip/compout response and can corrupt every Nth one.
module comparator_emulator #(
  parameter  int NHS   = 32,
  parameter  int CNT_W = 16,
  localparam int KW    = $clog2(NHS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  comparator_emulator_if.slave bus,
  input  logic [KW-1:0]     hs_key,
  input  logic [3:0]        hs_latency,
  input  logic [3:0]        hs_hold,
  input  logic [7:0]        err_every,
  input  logic [KW-1:0]     err_bit,
  output logic              busy,
  output logic [CNT_W-1:0]  pulse_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [7:0]        drop_cnt,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic            pulse_en_q;
  logic            rise;
  logic            accept, load, finish, drop;
  logic [3:0]      cnt, hcnt;
  logic [KW-1:0]   key_cap, err_bit_cap;
  logic [3:0]      lat_cap, hold_cap;
  logic            compin_cap, corrupt_cap;
  logic [7:0]      fault_cnt, fault_inc;
  logic            fault_hit;
  logic [NHS-1:0]  hit_word, flip_word;
  logic [NHS-1:0]  halfstrips_r;
  logic            compout_r;

  assign rise      = bus.pulse_en & ~pulse_en_q;
  assign fault_inc = fault_cnt + 8'd1;
  // Equality only: a counter already past a newly lowered err_every runs on and wraps.
  assign fault_hit = (err_every != 8'd0) && (fault_inc == err_every);
  assign hit_word  = compin_cap  ? (NHS'(1) << key_cap)     : '0;
  assign flip_word = corrupt_cap ? (NHS'(1) << err_bit_cap) : '0;

  assign bus.halfstrips = halfstrips_r;
  assign bus.compout    = compout_r;
  assign fsm_state      = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    load    = 1'b0;
    finish  = 1'b0;
    drop    = 1'b0;
    case (state)
      IDLE: begin
        if (rise && enable) begin
          accept  = 1'b1;
          state_n = DELAY;
        end
      end
      DELAY: begin
        drop = rise;
        if (cnt == lat_cap) begin
          load    = 1'b1;
          state_n = DRIVE;
        end
      end
      DRIVE: begin
        // An edge on the clearing cycle is still seen as busy and dropped.
        drop = rise;
        if (hcnt == hold_cap) begin
          finish  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_en_q   <= 1'b1;
      cnt          <= '0;
      hcnt         <= '0;
      key_cap      <= '0;
      err_bit_cap  <= '0;
      lat_cap      <= '0;
      hold_cap     <= '0;
      compin_cap   <= 1'b0;
      corrupt_cap  <= 1'b0;
      fault_cnt    <= '0;
      halfstrips_r <= '0;
      compout_r    <= 1'b0;
      busy         <= 1'b0;
      pulse_cnt    <= '0;
      err_cnt      <= '0;
      drop_cnt     <= '0;
    end else begin
      pulse_en_q <= bus.pulse_en;

      if (accept) begin
        key_cap     <= hs_key;
        err_bit_cap <= err_bit;
        lat_cap     <= hs_latency;
        hold_cap    <= hs_hold;
        compin_cap  <= bus.compin;
        corrupt_cap <= fault_hit;
        fault_cnt   <= fault_hit ? 8'd0 : fault_inc;
        pulse_cnt   <= pulse_cnt + CNT_W'(1);
        cnt         <= '0;
        busy        <= 1'b1;
      end

      if (state == DELAY && !load) cnt <= cnt + 4'd1;

      if (load) begin
        halfstrips_r <= hit_word ^ flip_word;
        compout_r    <= compin_cap ^ corrupt_cap;
        hcnt         <= '0;
        if (corrupt_cap && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
      end

      if (state == DRIVE && !finish) hcnt <= hcnt + 4'd1;

      if (finish) begin
        halfstrips_r <= '0;
        compout_r    <= 1'b0;
        busy         <= 1'b0;
      end

      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_comparator_emulator.sv
// Bench for comparator_emulator: table of single-pulse responses, hand sequences for
// faults, drops, gating and async reset, then random traffic against a timeline model.
module tb_comparator_emulator;
  localparam int NHS   = 32;
  localparam int CNT_W = 16;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic        enable     = 1'b0;
  logic [4:0]  hs_key     = '0;
  logic [4:0]  err_bit    = '0;
  logic [3:0]  hs_latency = '0;
  logic [3:0]  hs_hold    = '0;
  logic [7:0]  err_every  = '0;
  logic        busy;
  logic [15:0] pulse_cnt, err_cnt;
  logic [7:0]  drop_cnt;
  logic [1:0]  fsm_state;

  comparator_emulator_if #(.NHS(NHS)) bus ();

  comparator_emulator #(.NHS(NHS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .bus        (bus),
    .hs_key     (hs_key),
    .hs_latency (hs_latency),
    .hs_hold    (hs_hold),
    .err_every  (err_every),
    .err_bit    (err_bit),
    .busy       (busy),
    .pulse_cnt  (pulse_cnt),
    .err_cnt    (err_cnt),
    .drop_cnt   (drop_cnt),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // reference model: a response is a time window [start, end) derived from the accept cycle
  logic [31:0] exp_q[$];
  bit          m_pen_q;
  bit          m_txn;
  int          m_acc, m_start, m_end;
  logic [31:0] m_hs;
  bit          m_co, m_co_pend, m_corrupt;
  int          m_fault, m_pulse, m_err, m_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pen_q = 1'b1;
    m_txn   = 1'b0;
    m_hs    = '0;
    m_co    = 1'b0;
    m_fault = 0;
    m_pulse = 0;
    m_err   = 0;
    m_drop  = 0;
    exp_q.delete();
  endtask

  task automatic model_clock();
    bit          rise, corrupt;
    logic [31:0] v;
    if (!reset_n) return;
    rise    = bus.pulse_en && !m_pen_q;
    m_pen_q = bus.pulse_en;
    if (m_txn && cyc > m_acc && cyc <= m_end) begin
      if (rise && m_drop < 255) m_drop++;
    end else if (rise && enable) begin
      m_pulse = (m_pulse + 1) % 65536;
      m_fault = (m_fault + 1) % 256;
      corrupt = (err_every != 0) && (m_fault == int'(err_every));
      if (corrupt) m_fault = 0;
      v = bus.compin ? (32'd1 << hs_key) : 32'd0;
      if (corrupt) v = v ^ (32'd1 << err_bit);
      exp_q.push_back(v);
      m_co_pend = bus.compin ^ corrupt;
      m_corrupt = corrupt;
      m_txn     = 1'b1;
      m_acc     = cyc;
      m_start   = cyc + int'(hs_latency) + 1;
      m_end     = cyc + int'(hs_latency) + int'(hs_hold) + 2;
    end
    if (m_txn && cyc == m_start && exp_q.size() > 0) begin
      m_hs = exp_q.pop_front();
      m_co = m_co_pend;
      if (m_corrupt && m_err < 65535) m_err++;
    end
    if (m_txn && cyc == m_end) begin
      m_hs = '0;
      m_co = 1'b0;
    end
  endtask

  task automatic compare_all();
    bit eb;
    eb = m_txn && cyc >= m_acc && cyc < m_end;
    check("halfstrips", bus.halfstrips, m_hs);
    check("compout",    bus.compout,    m_co);
    check("busy",       busy,           eb);
    check("pulse_cnt",  pulse_cnt,      m_pulse);
    check("err_cnt",    err_cnt,        m_err);
    check("drop_cnt",   drop_cnt,       m_drop);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    cyc++;
    model_clock();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic send(input logic [3:0] l, input logic [3:0] h, input logic [4:0] key,
                      input logic ci, output logic [31:0] peak, output logic peak_co,
                      output int rise_k, output int hi_n);
    hs_latency   = l;
    hs_hold      = h;
    hs_key       = key;
    bus.compin   = ci;
    bus.pulse_en = 1'b1;
    peak = '0; peak_co = 1'b0; rise_k = -1; hi_n = 0;
    for (int k = 0; k < int'(l) + int'(h) + 4; k++) begin
      step();
      if (k == 0) bus.pulse_en = 1'b0;
      if (bus.halfstrips != '0 || bus.compout) begin
        if (rise_k < 0) rise_k = k;
        hi_n++;
        peak    = peak | bus.halfstrips;
        peak_co = peak_co | bus.compout;
      end
    end
  endtask

  typedef struct {
    logic [3:0]  l;
    logic [3:0]  h;
    logic [4:0]  key;
    logic        ci;
    logic [31:0] exp_hs;
    logic        exp_co;
    int          exp_rise;
    int          exp_hi;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] pk;
    logic        pco;
    int          rk, hn;

    vecs[0] = '{4'd3,  4'd2,  5'd7,  1'b1, 32'h0000_0080, 1'b1, 4,  3};
    vecs[1] = '{4'd0,  4'd0,  5'd0,  1'b1, 32'h0000_0001, 1'b1, 1,  1};
    vecs[2] = '{4'd15, 4'd15, 5'd31, 1'b1, 32'h8000_0000, 1'b1, 16, 16};
    vecs[3] = '{4'd2,  4'd1,  5'd5,  1'b0, 32'h0000_0000, 1'b0, -1, 0};
    vecs[4] = '{4'd1,  4'd3,  5'd16, 1'b1, 32'h0001_0000, 1'b1, 2,  4};

    bus.pulse_en = 1'b1;
    bus.compin   = 1'b0;
    model_reset();

    // pulse_en already high at reset release must not count as an edge
    step();
    step();
    reset_n = 1'b1;
    enable  = 1'b1;
    step();
    step();
    bus.pulse_en = 1'b0;
    step();
    check("no_edge_at_release", pulse_cnt, 16'd0);

    // single-pulse table
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].l, vecs[i].h, vecs[i].key, vecs[i].ci, pk, pco, rk, hn);
      check($sformatf("vec%0d_hs", i),   pk,  vecs[i].exp_hs);
      check($sformatf("vec%0d_co", i),   pco, vecs[i].exp_co);
      check($sformatf("vec%0d_rise", i), rk,  vecs[i].exp_rise);
      check($sformatf("vec%0d_hold", i), hn,  vecs[i].exp_hi);
    end
    check("table_pulse_cnt", pulse_cnt, 16'd5);

    // every third response corrupted on bit 0
    do_reset();
    err_every = 8'd3;
    err_bit   = 5'd0;
    for (int p = 1; p <= 6; p++) begin
      send(4'd1, 4'd0, 5'd4, 1'b1, pk, pco, rk, hn);
      check($sformatf("fault_p%0d_hs", p), pk,  (p % 3 == 0) ? 32'h11 : 32'h10);
      check($sformatf("fault_p%0d_co", p), pco, (p % 3 == 0) ? 1'b0 : 1'b1);
    end
    check("fault_err_cnt", err_cnt, 16'd2);
    err_every = 8'd0;

    // second edge during DELAY is dropped
    do_reset();
    hs_latency = 4'd8; hs_hold = 4'd1; hs_key = 5'd2; bus.compin = 1'b1;
    bus.pulse_en = 1'b1;
    step();
    bus.pulse_en = 1'b0;
    step(); step(); step();
    bus.pulse_en = 1'b1;
    step();
    bus.pulse_en = 1'b0;
    for (int k = 0; k < 10; k++) step();
    check("busy_drop_cnt",  drop_cnt,  8'd1);
    check("busy_pulse_cnt", pulse_cnt, 16'd1);

    // edge on the clearing cycle is dropped, the next one is accepted
    hs_latency = 4'd1; hs_hold = 4'd1;
    bus.pulse_en = 1'b1;
    step();
    bus.pulse_en = 1'b0;
    step(); step(); step();
    bus.pulse_en = 1'b1;
    step();
    bus.pulse_en = 1'b0;
    step();
    bus.pulse_en = 1'b1;
    step();
    bus.pulse_en = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("ret_drop_cnt",  drop_cnt,  8'd2);
    check("ret_pulse_cnt", pulse_cnt, 16'd3);

    // enable gating
    do_reset();
    enable = 1'b0;
    for (int p = 0; p < 3; p++) begin
      send(4'd1, 4'd1, 5'd3, 1'b1, pk, pco, rk, hn);
      check("gated_hs", pk, 32'd0);
    end
    check("gated_pulse_cnt", pulse_cnt, 16'd0);
    check("gated_drop_cnt",  drop_cnt,  8'd0);
    enable = 1'b1;
    send(4'd1, 4'd1, 5'd3, 1'b1, pk, pco, rk, hn);
    check("ungated_hs", pk, 32'h8);

    // asynchronous reset while driving
    bus.compin = 1'b1;
    hs_latency = 4'd2; hs_hold = 4'd5; hs_key = 5'd9;
    bus.pulse_en = 1'b1;
    step();
    bus.pulse_en = 1'b0;
    step(); step(); step(); step();
    check("drive_before_reset", bus.halfstrips, 32'h200);
    #2 reset_n = 1'b0;
    #1;
    check("arst_halfstrips", bus.halfstrips, 32'd0);
    check("arst_compout",    bus.compout,    1'b0);
    check("arst_busy",       busy,           1'b0);
    check("arst_pulse_cnt",  pulse_cnt,      16'd0);
    model_reset();
    step();
    reset_n = 1'b1;
    step(); step();

    // random traffic
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 2) == 0) bus.pulse_en = ~bus.pulse_en;
      bus.compin = 1'($urandom_range(0, 1));
      enable     = ($urandom_range(0, 9) != 0);
      hs_key     = 5'($urandom_range(0, 31));
      err_bit    = 5'($urandom_range(0, 31));
      hs_latency = 4'($urandom_range(0, 6));
      hs_hold    = 4'($urandom_range(0, 4));
      if ($urandom_range(0, 39) == 0) err_every = 8'($urandom_range(0, 5));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
